// File: rtl/rob_pkg.sv
// rob_pkg: shared sizing constants and typedefs for the dispatch -> ROB path.
//   ROB_DEPTH       ROB entries (and credit counter reset value)
//   DISPATCH_WIDTH  max instructions per rename group / per dispatch
//   BUNDLE_W        per-instruction bundle width
//   PREG_W          physical register tag width
//   CREDIT_W        width of a credit count, 0..ROB_DEPTH inclusive
package rob_pkg;
   localparam int ROB_DEPTH      = 16;
   localparam int DISPATCH_WIDTH = 4;
   localparam int BUNDLE_W       = 57;
   localparam int PREG_W         = 6;
   localparam int CREDIT_W       = $clog2(ROB_DEPTH) + 1;

   typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;
   typedef logic [PREG_W-1:0]            preg_t;
   typedef logic [BUNDLE_W-1:0]          bundle_t;
   typedef logic [CREDIT_W-1:0]          credit_t;
endpackage

// File: rtl/rob_credit_ctr.sv
// rob_credit_ctr: free-ROB-entry credit counter.
//   i_clk           clock
//   i_rst           synchronous active-high reset -> ROB_DEPTH
//   i_flush         ROB empties on this edge -> ROB_DEPTH, commits ignored
//   i_n             entries consumed by dispatch this cycle
//   i_commit_count  entries freed by commit this cycle
//   o_credits       registered free-entry count, 0..ROB_DEPTH
module rob_credit_ctr
   import rob_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_flush,
   input  logic [2:0]    i_n,
   input  logic [2:0]    i_commit_count,
   output logic [CW-1:0] o_credits
);

   // Dispatch and commit fold into a single update.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) o_credits <= CW'(DEPTH);
      else                  o_credits <= o_credits - CW'(i_n) + CW'(i_commit_count);
   end

   // Commit can only free entries that are occupied after this cycle's dispatch.
   always_ff @(posedge i_clk) begin
      if (!i_rst && !i_flush) begin
         assert (int'(i_commit_count) <= DEPTH - int'(o_credits) + int'(i_n));
         assert (int'(o_credits) <= DEPTH);
      end
   end

endmodule

// File: rtl/rob_dispatch_ctrl.sv
// rob_dispatch_ctrl: holds one rename group and dispatches it into the ROB
// as credits allow, keeping any undispatched remainder oldest-first.
//   i_clk / i_rst          clock, synchronous active-high reset
//   i_flush                pipeline flush (outranks accept and dispatch)
//   i_grp_valid/o_grp_ready rename group handshake
//   i_grp_count/bundle/old_p group contents, slot 0 oldest
//   i_commit_count         ROB entries freed this cycle
//   o_ins_count            instructions dispatched this cycle (rob.i_ins_count)
//   o_ins_bundle/old_p     held slots, slot 0 oldest
//   o_credits              registered free ROB entries
//   o_stall_cnt            saturating count of credit-stall cycles
module rob_dispatch_ctrl
   import rob_pkg::*;
#(
   parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
   parameter int WIDTH     = DISPATCH_WIDTH,
   parameter int BUNDLE_W  = rob_pkg::BUNDLE_W,
   parameter int PREG_W    = rob_pkg::PREG_W
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_flush,
   input  logic                          i_grp_valid,
   output logic                          o_grp_ready,
   input  logic [2:0]                    i_grp_count,
   input  logic [WIDTH*BUNDLE_W-1:0]     i_grp_bundle,
   input  logic [WIDTH*PREG_W-1:0]       i_grp_old_p,
   input  logic [2:0]                    i_commit_count,
   output logic [2:0]                    o_ins_count,
   output logic [WIDTH*BUNDLE_W-1:0]     o_ins_bundle,
   output logic [WIDTH*PREG_W-1:0]       o_ins_old_p,
   output logic [$clog2(ROB_DEPTH):0]    o_credits,
   output logic [15:0]                   o_stall_cnt
);

   localparam int CW = $clog2(ROB_DEPTH) + 1;
   localparam int IW = $clog2(2 * WIDTH);

   logic [2:0]                           hold_cnt;
   logic [WIDTH-1:0][BUNDLE_W-1:0]       hold_bundle;
   logic [WIDTH-1:0][PREG_W-1:0]         hold_old_p;
   logic [2*WIDTH-1:0][BUNDLE_W-1:0]     ext_bundle;
   logic [2*WIDTH-1:0][PREG_W-1:0]       ext_old_p;
   logic [WIDTH-1:0][BUNDLE_W-1:0]       shift_bundle;
   logic [WIDTH-1:0][PREG_W-1:0]         shift_old_p;
   logic [CW-1:0]                        credits;
   logic [2:0]                           n_avail;
   logic [2:0]                           n_disp;
   logic                                 accept;
   logic [IW-1:0]                        src;

   // n_avail is the credit-limited count; flush only masks what is sent.
   always_comb begin
      n_avail     = (credits < CW'(hold_cnt)) ? credits[2:0] : hold_cnt;
      n_disp      = i_flush ? 3'd0 : n_avail;
      o_grp_ready = !i_flush && (n_avail == hold_cnt);
      accept      = i_grp_valid && o_grp_ready;
   end

   // Remainder moves down by n_disp; zero padding above keeps the index in range.
   always_comb begin
      ext_bundle   = {{WIDTH*BUNDLE_W{1'b0}}, hold_bundle};
      ext_old_p    = {{WIDTH*PREG_W{1'b0}}, hold_old_p};
      shift_bundle = hold_bundle;
      shift_old_p  = hold_old_p;
      src          = '0;
      for (int k = 0; k < WIDTH; k++) begin
         src             = IW'(k) + IW'(n_disp);
         shift_bundle[k] = ext_bundle[src];
         shift_old_p[k]  = ext_old_p[src];
      end
   end

   // Slot data needs no reset: only slots below hold_cnt are meaningful.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         hold_bundle <= i_grp_bundle;
         hold_old_p  <= i_grp_old_p;
      end else begin
         hold_bundle <= shift_bundle;
         hold_old_p  <= shift_old_p;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) hold_cnt <= 3'd0;
      else if (accept)      hold_cnt <= i_grp_count;
      else                  hold_cnt <= hold_cnt - n_disp;
   end

   // Stall is counted on credit shortage, independent of flush.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_stall_cnt <= '0;
      else if (hold_cnt != 3'd0 && n_avail < hold_cnt && o_stall_cnt != 16'hFFFF)
         o_stall_cnt <= o_stall_cnt + 16'd1;
   end

   rob_credit_ctr #(.DEPTH(ROB_DEPTH), .CW(CW)) u_credit (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_flush        (i_flush),
      .i_n            (n_disp),
      .i_commit_count (i_commit_count),
      .o_credits      (credits)
   );

   assign o_ins_count  = n_disp;
   assign o_ins_bundle = hold_bundle;
   assign o_ins_old_p  = hold_old_p;
   assign o_credits    = credits;

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// Bench for rob_dispatch_ctrl: hand-computed vector table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_rob_dispatch_ctrl;
   localparam int W  = 4;
   localparam int BW = 57;
   localparam int PW = 6;
   localparam int D  = 16;

   logic            i_clk = 1'b0;
   logic            i_rst, i_flush, i_grp_valid, o_grp_ready;
   logic [2:0]      i_grp_count, i_commit_count, o_ins_count;
   logic [W*BW-1:0] i_grp_bundle, o_ins_bundle;
   logic [W*PW-1:0] i_grp_old_p, o_ins_old_p;
   logic [4:0]      o_credits;
   logic [15:0]     o_stall_cnt;

   rob_dispatch_ctrl #(.ROB_DEPTH(D), .WIDTH(W), .BUNDLE_W(BW), .PREG_W(PW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
      .i_grp_valid(i_grp_valid), .o_grp_ready(o_grp_ready),
      .i_grp_count(i_grp_count), .i_grp_bundle(i_grp_bundle), .i_grp_old_p(i_grp_old_p),
      .i_commit_count(i_commit_count), .o_ins_count(o_ins_count),
      .o_ins_bundle(o_ins_bundle), .o_ins_old_p(o_ins_old_p),
      .o_credits(o_credits), .o_stall_cnt(o_stall_cnt)
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit r, f, v;
      int cnt, cm;
      bit chk;
      int ins, rdy, cr, st;
   } vec_t;
   vec_t tbl[20];

   typedef struct {
      logic [BW-1:0] b;
      logic [PW-1:0] p;
   } ins_t;
   ins_t q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit r, f, v, input int cnt, cm, tag);
      i_rst = r; i_flush = f; i_grp_valid = v;
      i_grp_count = 3'(cnt); i_commit_count = 3'(cm);
      for (int k = 0; k < W; k++) begin
         i_grp_bundle[k*BW +: BW] = BW'(tag * 16 + k);
         i_grp_old_p[k*PW +: PW]  = PW'(tag + k);
      end
   endtask

   task automatic obs(input string nm, input int ins, rdy, cr, st);
      chk({nm, ".ins_count"}, longint'(o_ins_count), ins);
      chk({nm, ".grp_ready"}, longint'(o_grp_ready), rdy);
      chk({nm, ".credits"},   longint'(o_credits), cr);
      chk({nm, ".stall_cnt"}, longint'(o_stall_cnt), st);
   endtask

   initial begin
      int cr, st, n_raw, n, maxc, h;
      bit r, f, v, rdy;
      int cnt, cm;

      //           r f v cnt cm chk ins rdy cr st
      tbl[0]  = '{1,0,0, 0, 0, 0,  0, 0,  0, 0};
      tbl[1]  = '{0,0,1, 4, 0, 1,  0, 1, 16, 0};
      tbl[2]  = '{0,0,1, 4, 0, 1,  4, 1, 16, 0};
      tbl[3]  = '{0,0,1, 4, 0, 1,  4, 1, 12, 0};
      tbl[4]  = '{0,0,1, 4, 0, 1,  4, 1,  8, 0};
      tbl[5]  = '{0,0,1, 4, 0, 1,  4, 1,  4, 0};
      tbl[6]  = '{0,0,1, 4, 0, 1,  0, 0,  0, 0};
      tbl[7]  = '{0,0,0, 0, 3, 1,  0, 0,  0, 1};
      tbl[8]  = '{0,0,0, 0, 0, 1,  3, 0,  3, 2};
      tbl[9]  = '{0,0,0, 0, 4, 1,  0, 0,  0, 3};
      tbl[10] = '{0,0,1, 4, 0, 1,  1, 1,  4, 4};
      tbl[11] = '{0,0,1, 4, 4, 1,  3, 0,  3, 4};
      tbl[12] = '{0,0,1, 4, 4, 1,  1, 1,  4, 5};
      tbl[13] = '{0,0,1, 4, 4, 1,  4, 1,  7, 5};
      tbl[14] = '{0,1,1, 3, 0, 1,  0, 0,  7, 5};
      tbl[15] = '{0,0,0, 0, 0, 1,  0, 1, 16, 5};
      tbl[16] = '{0,0,1, 4, 0, 1,  0, 1, 16, 5};
      tbl[17] = '{1,0,0, 0, 0, 1,  4, 1, 16, 5};
      tbl[18] = '{0,0,1, 0, 0, 1,  0, 1, 16, 0};
      tbl[19] = '{0,0,0, 0, 0, 1,  0, 1, 16, 0};

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].cnt, tbl[i].cm, i);
         #1;
         if (tbl[i].chk) obs($sformatf("tbl%0d", i), tbl[i].ins, tbl[i].rdy, tbl[i].cr, tbl[i].st);
         @(negedge i_clk);
      end

      // Partial dispatch: 2 credits, group A..D held.
      drive(1,0,0,0,0,0); @(negedge i_clk);
      drive(0,0,1,4,0,1); @(negedge i_clk);
      drive(0,0,1,4,0,2); @(negedge i_clk);
      drive(0,0,1,4,0,3); @(negedge i_clk);
      drive(0,0,1,2,0,4); @(negedge i_clk);
      drive(0,0,1,4,0,5); #1; obs("pd_load", 2, 1, 4, 0); @(negedge i_clk);
      drive(0,0,0,0,0,0); #1; obs("pd_split", 2, 0, 2, 0);
      chk("pd_slot0_A", longint'(o_ins_bundle[0 +: BW]), 80);
      @(negedge i_clk);
      #1; obs("pd_rem", 0, 0, 0, 1);
      chk("pd_slot0_C", longint'(o_ins_bundle[0 +: BW]), 82);
      chk("pd_slot1_D", longint'(o_ins_bundle[BW +: BW]), 83);
      chk("pd_oldp0_C", longint'(o_ins_old_p[0 +: PW]), 7);
      chk("pd_oldp1_D", longint'(o_ins_old_p[PW +: PW]), 8);
      drive(0,0,0,0,3,0); @(negedge i_clk);
      // Drain remainder and load a 3-group while reaching 5 credits.
      drive(0,0,1,3,4,6); #1; obs("fl_prep", 2, 1, 3, 2); @(negedge i_clk);
      drive(0,1,1,4,0,7); #1; obs("fl_cycle", 0, 0, 5, 2);
      chk("fl_slot0", longint'(o_ins_bundle[0 +: BW]), 96);
      @(negedge i_clk);
      drive(0,0,0,0,0,0); #1; obs("fl_after", 0, 1, 16, 2); @(negedge i_clk);

      // Reset in the middle of a partial dispatch.
      for (int i = 0; i < 5; i++) begin drive(0,0,1,4,0,7); @(negedge i_clk); end
      drive(0,0,0,0,2,0); @(negedge i_clk);
      drive(1,0,0,0,0,0); #1; obs("rs_partial", 2, 0, 2, 3); @(negedge i_clk);
      drive(0,0,1,0,0,8); #1; obs("rs_after", 0, 1, 16, 0); @(negedge i_clk);
      drive(0,0,0,0,0,0); #1; obs("rs_cnt0", 0, 1, 16, 0); @(negedge i_clk);

      // Randomized traffic against the reference model.
      drive(1,0,0,0,0,0); @(negedge i_clk);
      q.delete(); cr = D; st = 0;
      for (int c = 0; c < 3000; c++) begin
         h     = q.size();
         n_raw = (h < cr) ? h : cr;
         f     = ($urandom % 16) == 0;
         r     = ($urandom % 64) == 0;
         v     = ($urandom % 4) != 0;
         cnt   = $urandom_range(0, W);
         n     = f ? 0 : n_raw;
         maxc  = D - cr + n;
         if (maxc > W) maxc = W;
         cm    = $urandom_range(0, maxc);
         rdy   = !f && (n_raw == h);
         i_rst = r; i_flush = f; i_grp_valid = v;
         i_grp_count = 3'(cnt); i_commit_count = 3'(cm);
         for (int k = 0; k < W; k++) begin
            i_grp_bundle[k*BW +: BW] = BW'({$urandom(), $urandom()});
            i_grp_old_p[k*PW +: PW]  = PW'($urandom());
         end
         #1;
         obs("rnd", n, int'(rdy), cr, st);
         for (int k = 0; k < h; k++) begin
            chk("rnd.bundle", longint'(o_ins_bundle[k*BW +: BW]), longint'(q[k].b));
            chk("rnd.old_p",  longint'(o_ins_old_p[k*PW +: PW]),  longint'(q[k].p));
         end
         @(negedge i_clk);
         if (r) begin
            q.delete(); cr = D; st = 0;
         end else begin
            if (h != 0 && n_raw < h && st < 65535) st++;
            if (f) begin
               q.delete(); cr = D;
            end else begin
               cr = cr - n + cm;
               if (v && rdy) begin
                  q.delete();
                  for (int k = 0; k < cnt; k++)
                     q.push_back('{i_grp_bundle[k*BW +: BW], i_grp_old_p[k*PW +: PW]});
               end else begin
                  repeat (n) void'(q.pop_front());
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
